// File: rtl/rr_arbiter16_if.sv
// Handshake bundle between the requesting agents and the round-robin arbiter.
// Requester side (master) drives the request vector and the owner release strobe.
// Arbiter side (slave) drives the one-hot grant, the mux select index and status flags.
interface rr_arbiter16_if #(
  parameter int N    = 16,
  parameter int IDXW = 4
);
  logic [N-1:0]    req;
  // Owner-finished strobe. "release" is a reserved word in SystemVerilog, hence "rel".
  logic            rel;
  logic [N-1:0]    gnt;
  logic [IDXW-1:0] gnt_idx;
  logic            gnt_valid;
  logic            timeout;

  modport master (
    output req,
    output rel,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  rel,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output timeout
  );
endinterface

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter sharing one N:1 select path; gnt_idx drives the mux select directly.
// Latency: a request sampled at edge k is granted after edge k; every grant is followed by a one-cycle idle bubble.
// Backpressure: the owner holds the grant until it releases, drops its request, or hits MAX_HOLD (timeout pulse).
module rr_arbiter16 #(
  parameter int N        = 16,
  parameter int IDXW     = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_arbiter16_if.slave bus
);

  // Hold counter must represent MAX_HOLD itself; keep at least one bit when the timeout is disabled.
  localparam int HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);
  localparam logic [N-1:0]  ONE      = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t          state;
  logic [IDXW-1:0] ptr;
  logic [HW-1:0]   hold_cnt;

  logic [IDXW-1:0] win;
  logic            found;
  logic            rel_end;
  logic            hold_end;

  // Priority scan starting at ptr; IDXW-bit addition wraps modulo N since N == 2**IDXW.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      logic [IDXW-1:0] cand;
      cand = ptr + IDXW'(i);
      if (!found && bus.req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  // End-of-grant causes: explicit/implicit release versus forced revocation at the hold limit.
  always_comb begin
    rel_end  = bus.rel || !bus.req[bus.gnt_idx];
    hold_end = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIM);
  end

  // Two-state arbitration FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      hold_cnt      <= '0;
      bus.gnt       <= '0;
      bus.gnt_idx   <= '0;
      bus.gnt_valid <= 1'b0;
      bus.timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.timeout <= 1'b0;
          if (found) begin
            state         <= GRANT;
            bus.gnt_valid <= 1'b1;
            bus.gnt_idx   <= win;
            bus.gnt       <= ONE << win;
            hold_cnt      <= HW'(1);
          end
        end
        GRANT: begin
          if (rel_end || hold_end) begin
            state         <= IDLE;
            bus.gnt_valid <= 1'b0;
            bus.gnt       <= '0;
            ptr           <= bus.gnt_idx + IDXW'(1);
            // A coincident release wins over the timeout: no pulse in that case.
            bus.timeout   <= hold_end && !rel_end;
          end else if ((MAX_HOLD != 0) && (hold_cnt != HOLD_LIM)) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
